// File: rtl/mm_pkg.sv
// mm_pkg -- shared definitions for the matrix-multiply sequencer.
//
// Contents:
//   state_t       sequencer state encoding
//   DIM_W         width of the M, K and N dimension fields
//   DIM_ONE       constant 1 at DIM_W bits, used by the index counters
//   M/K/N_MSB/LSB bit positions of the dimension fields inside the
//                 address-0 words of the input (M, K) and weight (N) SRAMs
package mm_pkg;

    localparam int DIM_W = 16;
    localparam logic [DIM_W-1:0] DIM_ONE = 1;

    // Input SRAM word 0 holds {M, K}; weight SRAM word 0 holds N in its low half.
    localparam int M_MSB = 31;
    localparam int M_LSB = 16;
    localparam int K_MSB = 15;
    localparam int K_LSB = 0;
    localparam int N_MSB = 15;
    localparam int N_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIM_RD,
        ST_DIM_CAP,
        ST_ISSUE,
        ST_DRAIN,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/mm_idx_cnt.sv
// mm_idx_cnt -- nested i/j/k loop counter for the matrix-multiply sequencer.
//
// k is the innermost (dot-product term), j the result column, i the result row.
//
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   clear            synchronous clear of i, j and k (start of a job)
//   k_step           advance k, wrapping to 0 after K-1
//   ij_step          advance j, wrapping to 0 and advancing i after N-1
//   dim_m/k/n        current job dimensions (nonzero while stepping)
//   k_first          k == 0
//   k_last           k == K-1
//   j_last           j == N-1
//   i_last           i == M-1
module mm_idx_cnt
    import mm_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             k_step,
    input  logic             ij_step,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    output logic             k_first,
    output logic             k_last,
    output logic             j_last,
    output logic             i_last
);

    logic [DIM_W-1:0] i;
    logic [DIM_W-1:0] j;
    logic [DIM_W-1:0] k;

    assign k_first = (k == '0);
    assign k_last  = (k == dim_k - DIM_ONE);
    assign j_last  = (j == dim_n - DIM_ONE);
    assign i_last  = (i == dim_m - DIM_ONE);

    // k wraps on its own so it is already 0 when the next element starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (k_step) begin
                k <= k_last ? '0 : k + DIM_ONE;
            end
            if (ij_step) begin
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + DIM_ONE;
                end else begin
                    j <= j + DIM_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl -- control sequencer for an SRAM-based matrix multiply C = A x B.
//
// Reads the dimensions from word 0 of both source SRAMs, then for every result
// element issues K address pairs, lets the external MAC drain, and writes the
// accumulator to result address i*N+j.
//
// Ports:
//   clk, reset_n                    clock and asynchronous active-low reset
//   dut_valid / dut_ready           job start handshake (valid sampled in IDLE)
//   input_rd_addr / input_rd_data   matrix A SRAM (row-major, 1-cycle latency)
//   weight_rd_addr / weight_rd_data matrix B SRAM (column-major, 1-cycle latency)
//   mac_en, mac_first               external MAC accumulate / restart strobes
//   result_we, result_waddr         result SRAM write strobe and address
//   cycle_cnt                       busy-cycle counter, only when the macro
//                                   MM_SEQ_CYCLE_CNT_EN is defined
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] input_rd_addr,
    input  logic [DATA_W-1:0] input_rd_data,
    output logic [ADDR_W-1:0] weight_rd_addr,
    input  logic [DATA_W-1:0] weight_rd_data,
    output logic              mac_en,
    output logic              mac_first,
    output logic              result_we,
    output logic [ADDR_W-1:0] result_waddr
`ifdef MM_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t           state;
    logic [DIM_W-1:0] dim_m;
    logic [DIM_W-1:0] dim_k;
    logic [DIM_W-1:0] dim_n;

    // Start addresses of the current A row (1+i*K) and B column (1+j*K).
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_base;
    logic [ADDR_W-1:0] next_row;
    logic [ADDR_W-1:0] next_col;
    logic [ADDR_W-1:0] k_ext;

    logic k_first;
    logic k_last;
    logic j_last;
    logic i_last;
    logic dim_zero;
    logic unused_data;

    assign unused_data = ^{input_rd_data, weight_rd_data};
    assign k_ext       = ADDR_W'(dim_k);
    assign dim_zero    = (input_rd_data[M_MSB:M_LSB] == '0) ||
                         (input_rd_data[K_MSB:K_LSB] == '0) ||
                         (weight_rd_data[N_MSB:N_LSB] == '0);

    mm_idx_cnt u_idx_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ST_DIM_CAP),
        .k_step  (state == ST_ISSUE),
        .ij_step (state == ST_WRITE),
        .dim_m   (dim_m),
        .dim_k   (dim_k),
        .dim_n   (dim_n),
        .k_first (k_first),
        .k_last  (k_last),
        .j_last  (j_last),
        .i_last  (i_last)
    );

    // Bases for the element after the current one; addresses advance by K per
    // column or row step instead of multiplying, truncated to ADDR_W bits.
    always_comb begin
        next_row = row_base;
        next_col = col_base + k_ext;
        if (j_last) begin
            next_row = row_base + k_ext;
            next_col = ADDR_ONE;
        end
    end

    // Sequencer. Strobes are registered one cycle behind the state that causes
    // them, which matches the 1-cycle SRAM latency: data for an ISSUE address
    // arrives together with its mac_en, and the write lands in WRITE.
    // Results are produced in row-major order, so i*N+j is a running count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            dut_ready      <= 1'b1;
            mac_en         <= 1'b0;
            mac_first      <= 1'b0;
            result_we      <= 1'b0;
            input_rd_addr  <= '0;
            weight_rd_addr <= '0;
            result_waddr   <= '0;
            row_base       <= '0;
            col_base       <= '0;
            dim_m          <= '0;
            dim_k          <= '0;
            dim_n          <= '0;
        end else begin
            mac_en    <= (state == ST_ISSUE);
            mac_first <= (state == ST_ISSUE) && k_first;
            result_we <= (state == ST_DRAIN);
            case (state)
                ST_IDLE: begin
                    if (dut_valid) begin
                        state          <= ST_DIM_RD;
                        dut_ready      <= 1'b0;
                        input_rd_addr  <= '0;
                        weight_rd_addr <= '0;
                        result_waddr   <= '0;
                    end
                end
                ST_DIM_RD: begin
                    state <= ST_DIM_CAP;
                end
                ST_DIM_CAP: begin
                    dim_m <= input_rd_data[M_MSB:M_LSB];
                    dim_k <= input_rd_data[K_MSB:K_LSB];
                    dim_n <= weight_rd_data[N_MSB:N_LSB];
                    if (dim_zero) begin
                        state     <= ST_IDLE;
                        dut_ready <= 1'b1;
                    end else begin
                        state          <= ST_ISSUE;
                        row_base       <= ADDR_ONE;
                        col_base       <= ADDR_ONE;
                        input_rd_addr  <= ADDR_ONE;
                        weight_rd_addr <= ADDR_ONE;
                    end
                end
                ST_ISSUE: begin
                    if (k_last) begin
                        state <= ST_DRAIN;
                    end else begin
                        input_rd_addr  <= input_rd_addr + ADDR_ONE;
                        weight_rd_addr <= weight_rd_addr + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (i_last && j_last) begin
                        state     <= ST_IDLE;
                        dut_ready <= 1'b1;
                    end else begin
                        state          <= ST_ISSUE;
                        row_base       <= next_row;
                        col_base       <= next_col;
                        input_rd_addr  <= next_row;
                        weight_rd_addr <= next_col;
                        result_waddr   <= result_waddr + ADDR_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dut_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MM_SEQ_CYCLE_CNT_EN
    // Counts every busy cycle of the latest job; restarts when a job is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (dut_valid) begin
                cycle_cnt <= '0;
            end
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl -- directed self-checking bench for mm_seq_ctrl.
//
// Two behavioural SRAMs with 1-cycle read latency feed the sequencer. A
// negedge monitor records result write addresses, mac_first flags, the
// address pair issued the cycle before each mac_en, and busy cycles; each
// test task compares those records with hand-computed values.
module tb_mm_seq_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              dut_valid = 1'b0;
    logic              dut_ready;
    logic [ADDR_W-1:0] input_rd_addr;
    logic [DATA_W-1:0] input_rd_data;
    logic [ADDR_W-1:0] weight_rd_addr;
    logic [DATA_W-1:0] weight_rd_data;
    logic              mac_en;
    logic              mac_first;
    logic              result_we;
    logic [ADDR_W-1:0] result_waddr;
`ifdef MM_SEQ_CYCLE_CNT_EN
    logic [31:0]       cycle_cnt;
`endif

    logic [DATA_W-1:0] input_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] weight_mem [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_fail = 0;
    int busy_cnt = 0;

    logic [ADDR_W-1:0]   wr_q[$];
    bit                  first_q[$];
    logic [2*ADDR_W-1:0] pair_q[$];
    logic [ADDR_W-1:0]   prev_in = '0;
    logic [ADDR_W-1:0]   prev_w = '0;

    mm_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dut_valid      (dut_valid),
        .dut_ready      (dut_ready),
        .input_rd_addr  (input_rd_addr),
        .input_rd_data  (input_rd_data),
        .weight_rd_addr (weight_rd_addr),
        .weight_rd_data (weight_rd_data),
        .mac_en         (mac_en),
        .mac_first      (mac_first),
        .result_we      (result_we),
        .result_waddr   (result_waddr)
`ifdef MM_SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        input_rd_data  <= input_mem[input_rd_addr];
        weight_rd_data <= weight_mem[weight_rd_addr];
    end

    always @(negedge clk) begin
        if (result_we) wr_q.push_back(result_waddr);
        if (mac_en) begin
            first_q.push_back(mac_first);
            pair_q.push_back({prev_in, prev_w});
        end
        if (!dut_ready) busy_cnt++;
        prev_in = input_rd_addr;
        prev_w  = weight_rd_addr;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic load_dims(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n);
        input_mem[0]  = {m, k};
        weight_mem[0] = {16'd0, n};
    endtask

    // Raises dut_valid at an idle negedge; returns one negedge after acceptance.
    task automatic start_job(input bit hold);
        @(negedge clk);
        wr_q.delete();
        first_q.delete();
        pair_q.delete();
        busy_cnt = 0;
        dut_valid = 1'b1;
        @(negedge clk);
        if (!hold) dut_valid = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (dut_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dut_ready, mac_en, mac_first, result_we} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b required 1000", {dut_ready, mac_en, mac_first, result_we});
        end
        n_cmp++;
        if (input_rd_addr !== '0 || weight_rd_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_rd_addr: got %0d/%0d required 0/0", input_rd_addr, weight_rd_addr);
        end
        n_cmp++;
        if (result_waddr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_waddr: got %0d required 0", result_waddr);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_ready: got %b required 1", dut_ready);
        end
    endtask

    // 2x2x2: four elements of K+2=4 cycles after 2 dimension cycles.
    task automatic test_basic;
        bit ok;
        int exp_in[8] = '{1, 2, 1, 2, 3, 4, 3, 4};
        int exp_w[8]  = '{1, 2, 3, 4, 1, 2, 3, 4};
        logic [2*ADDR_W-1:0] got;
        load_dims(16'd2, 16'd2, 16'd2);
        start_job(1'b0);
        n_cmp++;
        if (dut_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_accept: dut_ready got %b required 0", dut_ready);
        end
        wait_ready(200, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL basic_done: dut_ready got 0 required 1 within 200 cycles");
        end
        n_cmp++;
        if (busy_cnt != 18) begin
            n_fail++;
            $display("[TB] FAIL basic_busy: got %0d required 18", busy_cnt);
        end
        n_cmp++;
        if (wr_q.size() != 4 || first_q.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL basic_counts: writes %0d macs %0d required 4 and 8", wr_q.size(), first_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= wr_q.size() || wr_q[i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("[TB] FAIL basic_waddr[%0d]: got %0d required %0d", i, (i < wr_q.size()) ? int'(wr_q[i]) : -1, i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < pair_q.size()) ? pair_q[i] : '1;
            n_cmp++;
            if (got !== {ADDR_W'(exp_in[i]), ADDR_W'(exp_w[i])} || i >= first_q.size() || first_q[i] != (i % 2 == 0)) begin
                n_fail++;
                $display("[TB] FAIL basic_mac[%0d]: got addr %0d/%0d required %0d/%0d (mac_first required %0d)",
                         i, got[2*ADDR_W-1:ADDR_W], got[ADDR_W-1:0], exp_in[i], exp_w[i], (i % 2 == 0));
            end
        end
`ifdef MM_SEQ_CYCLE_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'd18) begin
            n_fail++;
            $display("[TB] FAIL cycle_cnt_done: got %0d required 18", cycle_cnt);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cycle_cnt !== 32'd18) begin
            n_fail++;
            $display("[TB] FAIL cycle_cnt_hold: got %0d required 18", cycle_cnt);
        end
`endif
    endtask

    // K=1: each element is one ISSUE, every mac_en carries mac_first.
    task automatic test_k1;
        bit ok;
        logic [2*ADDR_W-1:0] got;
        load_dims(16'd1, 16'd1, 16'd3);
        start_job(1'b0);
        wait_ready(100, ok);
        n_cmp++;
        if (!ok || busy_cnt != 11) begin
            n_fail++;
            $display("[TB] FAIL k1_busy: got %0d (done %0d) required 11", busy_cnt, ok);
        end
        n_cmp++;
        if (wr_q.size() != 3 || first_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL k1_counts: writes %0d macs %0d required 3 and 3", wr_q.size(), first_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pair_q.size()) ? pair_q[i] : '1;
            n_cmp++;
            if (i >= wr_q.size() || wr_q[i] !== ADDR_W'(i) || i >= first_q.size() || first_q[i] != 1'b1 ||
                got !== {ADDR_W'(1), ADDR_W'(i + 1)}) begin
                n_fail++;
                $display("[TB] FAIL k1_elem[%0d]: got addr %0d/%0d required 1/%0d, waddr %0d required %0d",
                         i, got[2*ADDR_W-1:ADDR_W], got[ADDR_W-1:0], i + 1,
                         (i < wr_q.size()) ? int'(wr_q[i]) : -1, i);
            end
        end
    endtask

    // A zero dimension ends the job right after the dimension read.
    task automatic test_zero_dim;
        bit ok;
        logic [15:0] dims[2][3] = '{'{16'd2, 16'd0, 16'd2}, '{16'd0, 16'd3, 16'd3}};
        for (int t = 0; t < 2; t++) begin
            load_dims(dims[t][0], dims[t][1], dims[t][2]);
            start_job(1'b0);
            wait_ready(50, ok);
            n_cmp++;
            if (!ok || busy_cnt != 2) begin
                n_fail++;
                $display("[TB] FAIL zero_dim_busy[%0d]: got %0d (done %0d) required 2", t, busy_cnt, ok);
            end
            n_cmp++;
            if (wr_q.size() != 0 || first_q.size() != 0) begin
                n_fail++;
                $display("[TB] FAIL zero_dim_strobes[%0d]: writes %0d macs %0d required 0 and 0", t, wr_q.size(), first_q.size());
            end
        end
    endtask

    // Reset lands mid-ISSUE of a 3x3x3 job, between clock edges.
    task automatic test_reset_mid;
        bit ok;
        load_dims(16'd3, 16'd3, 16'd3);
        start_job(1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (input_rd_addr !== ADDR_W'(2) || weight_rd_addr !== ADDR_W'(2) || mac_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_issue: addr %0d/%0d mac_en %b required 2/2 and 1", input_rd_addr, weight_rd_addr, mac_en);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({dut_ready, mac_en, mac_first, result_we} !== 4'b1000 || input_rd_addr !== '0 || weight_rd_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: strobes %b addr %0d/%0d required 1000 and 0/0",
                     {dut_ready, mac_en, mac_first, result_we}, input_rd_addr, weight_rd_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wr_q.delete();
        first_q.delete();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != 0 || first_q.size() != 0 || dut_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_quiet: writes %0d macs %0d ready %b required 0, 0, 1", wr_q.size(), first_q.size(), dut_ready);
        end
        load_dims(16'd2, 16'd2, 16'd2);
        start_job(1'b0);
        wait_ready(200, ok);
        n_cmp++;
        if (!ok || busy_cnt != 18 || wr_q.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL post_reset_job: busy %0d writes %0d required 18 and 4", busy_cnt, wr_q.size());
        end
        n_cmp++;
        if (wr_q.size() == 4 && (wr_q[0] !== 0 || wr_q[3] !== 3)) begin
            n_fail++;
            $display("[TB] FAIL post_reset_waddr: got first %0d last %0d required 0 and 3", wr_q[0], wr_q[3]);
        end
    endtask

    // dut_valid held high through a 2x3x2 job: 2 + 4*(3+2) = 22 busy cycles.
    task automatic test_back_to_back;
        bit ok;
        load_dims(16'd2, 16'd3, 16'd2);
        start_job(1'b1);
        wait_ready(300, ok);
        n_cmp++;
        if (!ok || busy_cnt != 22 || wr_q.size() != 4 || first_q.size() != 12) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: busy %0d writes %0d macs %0d required 22, 4, 12", busy_cnt, wr_q.size(), first_q.size());
        end
        wr_q.delete();
        first_q.delete();
        pair_q.delete();
        busy_cnt = 0;
        @(negedge clk);
        n_cmp++;
        if (dut_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_second_accept: dut_ready got %b required 0", dut_ready);
        end
        dut_valid = 1'b0;
        wait_ready(300, ok);
        n_cmp++;
        if (!ok || busy_cnt != 22 || wr_q.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: busy %0d writes %0d required 22 and 4", busy_cnt, wr_q.size());
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_ready !== 1'b1 || wr_q.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL b2b_no_queue: ready %b writes %0d required 1 and 4", dut_ready, wr_q.size());
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            input_mem[a]  = 32'(a);
            weight_mem[a] = 32'(a) ^ 32'h5a5a_0000;
        end
        $display("[TB] mm_seq_ctrl directed bench starting");
        test_reset;
        test_basic;
        test_k1;
        test_zero_dim;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
